light_fade_pwm: RTL and testbench

//  Downstream output stage of the light-stand datapath. Consumes the 3-bit brightness state from the

---
 rtl/light_fade_pwm.sv | 145 ++++++++++++++
 tb/tb_light_fade_pwm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/light_fade_pwm.sv
// Lamp PWM output stage: maps the requested brightness level to a target duty and fades
// the applied duty toward it in fixed steps, updating only at PWM period boundaries.
module light_fade_pwm #(
  parameter int unsigned PWM_BITS     = 10,
  parameter int unsigned PWM_DIV      = 100,
  parameter int unsigned RAMP_PERIODS = 4,
  parameter int unsigned STEP         = 16,
  parameter int unsigned DUTY_L1      = 200,
  parameter int unsigned DUTY_L2      = 400,
  parameter int unsigned DUTY_L3      = 600,
  parameter int unsigned DUTY_L4      = 800
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [2:0]          i_level,
  input  logic                i_force_off,
  output logic                o_pwm,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_busy
);

  localparam int unsigned PRESC_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int unsigned RAMP_W  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int unsigned EXT_W   = PWM_BITS + 1;

  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PWM_DIV - 1);
  localparam logic [RAMP_W-1:0]   RAMP_LAST  = RAMP_W'(RAMP_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
  localparam logic [EXT_W-1:0]    STEP_X     = EXT_W'(STEP);
  localparam logic [PWM_BITS-1:0] STEP_N     = PWM_BITS'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  state_t              r_state;
  logic [PRESC_W-1:0]  r_presc;
  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic [RAMP_W-1:0]   r_ramp;
  logic                r_pwm;

  logic                w_tick;
  logic                w_pend;
  logic [PWM_BITS-1:0] w_target;
  logic                w_below;
  logic                w_above;
  logic [EXT_W-1:0]    w_gap;
  logic                w_step_hit;
  logic [PWM_BITS-1:0] w_step_val;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_pend = w_tick && (r_cnt == CNT_MAX);

  // Requested level to target duty; force-off overrides everything
  always_comb begin
    w_target = '0;
    if (!i_force_off) begin
      case (i_level)
        3'd1:    w_target = PWM_BITS'(DUTY_L1);
        3'd2:    w_target = PWM_BITS'(DUTY_L2);
        3'd3:    w_target = PWM_BITS'(DUTY_L3);
        3'd4:    w_target = PWM_BITS'(DUTY_L4);
        default: w_target = '0;
      endcase
    end
  end

  // Distance to target is computed one bit wider so a step can never wrap past it
  always_comb begin
    w_below    = (r_duty < w_target);
    w_above    = (r_duty > w_target);
    w_gap      = w_below ? ({1'b0, w_target} - {1'b0, r_duty})
                         : ({1'b0, r_duty} - {1'b0, w_target});
    w_step_hit = (w_gap <= STEP_X);
    w_step_val = w_below ? (r_duty + STEP_N) : (r_duty - STEP_N);
  end

  // Prescaler and PWM period counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_pwm <= (r_cnt < r_duty);
      if (w_tick) begin
        r_presc <= '0;
        r_cnt   <= r_cnt + PWM_BITS'(1);
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end
    end
  end

  // Fade FSM, advanced only at period ends so the applied pulse never glitches
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_ramp  <= '0;
    end else if (w_pend) begin
      if (i_force_off) begin
        r_state <= ST_IDLE;
        r_duty  <= '0;
        r_ramp  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_ramp <= '0;
            if (w_below)      r_state <= ST_UP;
            else if (w_above) r_state <= ST_DOWN;
          end
          default: begin
            if (!w_below && !w_above) begin
              r_state <= ST_IDLE;
              r_ramp  <= '0;
            end else begin
              // Direction follows the live target; ramp phase survives a reversal
              r_state <= w_below ? ST_UP : ST_DOWN;
              if (r_ramp == RAMP_LAST) begin
                r_ramp <= '0;
                if (w_step_hit) begin
                  r_duty  <= w_target;
                  r_state <= ST_IDLE;
                end else begin
                  r_duty <= w_step_val;
                end
              end else begin
                r_ramp <= r_ramp + RAMP_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

  assign o_pwm  = r_pwm;
  assign o_duty = r_duty;
  assign o_busy = i_reset && (r_duty != w_target);

endmodule

// File: tb/tb_light_fade_pwm.sv
// Directed bench for light_fade_pwm: table of per-period vectors plus hand-written
// sequences for reset, mid-period level changes and reset during a fade.
module tb_light_fade_pwm;

  localparam int unsigned PWM_BITS = 4;
  localparam int unsigned PER_CLK  = 32;  // 16 ticks x 2 clocks

  typedef struct {
    logic [2:0] lvl;
    logic       frc;
    int         nper;
    int         duty;
    int         busy;
    int         hi;    // expected o_pwm-high clocks over the window, -1 = not checked
  } vec_t;

  logic                clk;
  logic                rst_n;
  logic [2:0]          level;
  logic                force_off;
  logic                pwm;
  logic [PWM_BITS-1:0] duty;
  logic                busy;

  int   n_checks;
  int   n_errors;
  vec_t tv[$];

  light_fade_pwm #(
    .PWM_BITS(PWM_BITS), .PWM_DIV(2), .RAMP_PERIODS(2), .STEP(3),
    .DUTY_L1(3), .DUTY_L2(6), .DUTY_L3(9), .DUTY_L4(15)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_level(level), .i_force_off(force_off),
    .o_pwm(pwm), .o_duty(duty), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] l, input logic f, input int n, input int d,
                     input int b, input int h);
    vec_t v;
    v.lvl = l; v.frc = f; v.nper = n; v.duty = d; v.busy = b; v.hi = h;
    tv.push_back(v);
  endtask

  // Runs n whole periods from just after a period end, counting o_pwm-high clocks
  task automatic run_periods(input int n, output int hi);
    hi = 0;
    repeat (n * PER_CLK) begin
      @(posedge clk);
      #1;
      hi += int'(pwm);
    end
  endtask

  task automatic apply_vecs(input int lo, input int hi_idx);
    int h;
    for (int i = lo; i <= hi_idx; i++) begin
      level     = tv[i].lvl;
      force_off = tv[i].frc;
      run_periods(tv[i].nper, h);
      check($sformatf("vec%0d duty", i), int'(duty), tv[i].duty);
      check($sformatf("vec%0d busy", i), int'(busy), tv[i].busy);
      if (tv[i].hi >= 0) check($sformatf("vec%0d pwm_high", i), h, tv[i].hi);
    end
  endtask

  initial begin
    int h;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b1;
    level     = 3'd0;
    force_off = 1'b0;

    // Up fade 0 -> 15, then hold at full duty
    add(4,0,1, 0,1,-1); add(4,0,1, 0,1,-1); add(4,0,1, 3,1,-1); add(4,0,2, 6,1,-1);
    add(4,0,2, 9,1,-1); add(4,0,2,12,1,-1); add(4,0,2,15,0,-1); add(4,0,1,15,0,30);
    // Down toward 0, forced off at 12, fade restarts from 0
    add(0,0,1,15,1,-1); add(0,0,1,15,1,-1); add(0,0,1,12,1,-1); add(0,1,1, 0,0,-1);
    add(4,1,1, 0,0, 0); add(4,0,1, 0,1,-1); add(4,0,1, 0,1,-1); add(4,0,1, 3,1,-1);
    // Clamp: 0 -> 3, 3 -> 6, 6 -> 3
    add(1,1,1, 0,0,-1); add(1,0,1, 0,1,-1); add(1,0,1, 0,1,-1); add(1,0,1, 3,0,-1);
    add(1,0,2, 3,0,12); add(2,0,1, 3,1,-1); add(2,0,1, 3,1,-1); add(2,0,1, 6,0,-1);
    add(2,0,2, 6,0,-1); add(1,0,1, 6,1,-1); add(1,0,1, 6,1,-1); add(1,0,1, 3,0,-1);
    add(1,0,2, 3,0,-1);
    // Reversal at 9 back to level 1
    add(4,0,1, 3,1,-1); add(4,0,1, 3,1,-1); add(4,0,1, 6,1,-1); add(4,0,2, 9,1,-1);
    add(1,0,1, 9,1,-1); add(1,0,1, 6,1,-1); add(1,0,2, 3,0,-1); add(1,0,2, 3,0,-1);
    // Level 6 acts as 0 (after the mid-period sequence)
    add(6,0,1, 3,1,-1); add(6,0,1, 0,0,-1); add(6,0,2, 0,0, 0);

    // Reset held while level toggles
    #2 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      level = 3'(i);
      @(posedge clk);
      #1;
      check($sformatf("rst%0d pwm", i), int'(pwm), 0);
      check($sformatf("rst%0d duty", i), int'(duty), 0);
      check($sformatf("rst%0d busy", i), int'(busy), 0);
    end
    level = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;

    apply_vecs(0, 36);

    // Level changes mid-period: duty and pulse width hold until the period end
    h = 0;
    for (int i = 0; i < int'(PER_CLK); i++) begin
      @(posedge clk);
      #1;
      h += int'(pwm);
      if (i == 10) level = 3'd4;
      if (i == 12) begin
        check("mid4 duty", int'(duty), 3);
        check("mid4 busy", int'(busy), 1);
      end
      if (i == 20) level = 3'd6;
      if (i == 22) begin
        check("mid6 duty", int'(duty), 3);
        check("mid6 busy", int'(busy), 1);
      end
    end
    check("mid pwm_high", h, 6);
    check("mid end duty", int'(duty), 3);

    apply_vecs(37, 39);

    // Reset asserted mid-fade, then fade restarts from 0
    level = 3'd2;
    run_periods(3, h);
    check("pre_rst duty", int'(duty), 3);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst duty", int'(duty), 0);
    check("async_rst pwm", int'(pwm), 0);
    check("async_rst busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("held_rst duty", int'(duty), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_periods(1, h);
    check("restart0 duty", int'(duty), 0);
    check("restart0 busy", int'(busy), 1);
    run_periods(2, h);
    check("restart1 duty", int'(duty), 3);
    run_periods(2, h);
    check("restart2 duty", int'(duty), 6);
    check("restart2 busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
